// File: rtl/multi_zone_ac_controller.sv
// multi_zone_ac_controller
//
// Runs N_ZONES independent four-state climate FSMs (OFF, DECREASE, INCREASE,
// IDLE) behind one shared power switch. Each zone compares its own temperature
// against its own setpoint with a +/-HYST hysteresis band. Each zone also
// holds DECREASE/INCREASE/IDLE for at least MIN_DWELL cycles before a non-OFF
// exit, which protects the compressor from short cycling.
//
// Optional feature, enabled by defining the macro STAGGER_START_EN:
//   At most one zone per edge may start the compressor, that is enter
//   DECREASE/INCREASE from OFF or IDLE. The lowest-index requesting zone wins,
//   and the other requesting zones hold their state and retry on the next edge.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset (all zones -> OFF)
//   power          global enable; 0 forces every zone to OFF
//   setpoint       zone z at [z*TEMP_W +: TEMP_W], unsigned
//   temp           measured temperature, same packing, unsigned
//   action         zone z at [2z +: 2]; OFF=11 DECREASE=01 INCREASE=10 IDLE=00
//   state_display  zone z at [2z +: 2]; OFF=0 DECREASE=1 INCREASE=2 IDLE=3
//   compressor_on  high when any zone is in DECREASE or INCREASE
module multi_zone_ac_controller #(
   parameter int N_ZONES   = 2,
   parameter int TEMP_W    = 8,
   parameter int HYST      = 2,
   parameter int MIN_DWELL = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        power,
   input  logic [N_ZONES*TEMP_W-1:0]   setpoint,
   input  logic [N_ZONES*TEMP_W-1:0]   temp,
   output logic [2*N_ZONES-1:0]        action,
   output logic [2*N_ZONES-1:0]        state_display,
   output logic                        compressor_on
);

   localparam int                CNT_W     = $clog2(MIN_DWELL + 1);
   localparam logic [TEMP_W:0]   HYST_X    = (TEMP_W + 1)'(HYST);
   localparam logic [CNT_W-1:0]  DWELL_MAX = CNT_W'(MIN_DWELL - 1);

   // The encoding equals the state_display code.
   typedef enum logic [1:0] {
      ST_OFF      = 2'd0,
      ST_DECREASE = 2'd1,
      ST_INCREASE = 2'd2,
      ST_IDLE     = 2'd3
   } zone_state_t;

   zone_state_t       state_r      [N_ZONES];
   zone_state_t       state_next_s [N_ZONES];
   logic [CNT_W-1:0]  cnt_r        [N_ZONES];
   logic [CNT_W-1:0]  cnt_next_s   [N_ZONES];

   // Next-state and dwell-counter logic for every zone
   always_comb begin
      logic [TEMP_W:0] sp_x;
      logic [TEMP_W:0] tp_x;
      logic            hot;
      logic            cold;
      logic            dwell_ok;
`ifdef STAGGER_START_EN
      logic            start;
      logic            grant_taken;
      grant_taken = 1'b0;
      start       = 1'b0;
`endif
      sp_x     = '0;
      tp_x     = '0;
      hot      = 1'b0;
      cold     = 1'b0;
      dwell_ok = 1'b0;
      for (int z = 0; z < N_ZONES; z++) begin
         // Comparisons use one extra bit so that sp+HYST and tp+HYST cannot wrap.
         sp_x     = {1'b0, setpoint[z*TEMP_W +: TEMP_W]};
         tp_x     = {1'b0, temp[z*TEMP_W +: TEMP_W]};
         hot      = (tp_x > (sp_x + HYST_X));
         cold     = ((tp_x + HYST_X) < sp_x);
         dwell_ok = (cnt_r[z] == DWELL_MAX);

         state_next_s[z] = state_r[z];
         if (!power) begin
            state_next_s[z] = ST_OFF;
         end else begin
            case (state_r[z])
               ST_OFF: begin
                  if (hot) begin
                     state_next_s[z] = ST_DECREASE;
                  end else if (cold) begin
                     state_next_s[z] = ST_INCREASE;
                  end else begin
                     state_next_s[z] = ST_IDLE;
                  end
               end
               ST_DECREASE: begin
                  if (dwell_ok && (tp_x <= sp_x)) begin
                     state_next_s[z] = ST_IDLE;
                  end else begin
                     state_next_s[z] = ST_DECREASE;
                  end
               end
               ST_INCREASE: begin
                  if (dwell_ok && (tp_x >= sp_x)) begin
                     state_next_s[z] = ST_IDLE;
                  end else begin
                     state_next_s[z] = ST_INCREASE;
                  end
               end
               ST_IDLE: begin
                  if (dwell_ok && hot) begin
                     state_next_s[z] = ST_DECREASE;
                  end else if (dwell_ok && cold) begin
                     state_next_s[z] = ST_INCREASE;
                  end else begin
                     state_next_s[z] = ST_IDLE;
                  end
               end
               default: state_next_s[z] = ST_OFF;
            endcase
         end

`ifdef STAGGER_START_EN
         // A compressor start is a move from OFF/IDLE into DECREASE/INCREASE.
         // Only the first such request (lowest zone index) is granted this edge.
         start = ((state_r[z] == ST_OFF) || (state_r[z] == ST_IDLE)) &&
                 ((state_next_s[z] == ST_DECREASE) || (state_next_s[z] == ST_INCREASE));
         if (start && grant_taken) begin
            state_next_s[z] = state_r[z];
         end else if (start) begin
            grant_taken = 1'b1;
         end else begin
            grant_taken = grant_taken;
         end
`endif

         // The counter restarts on entry to a state and saturates at the dwell limit.
         if (state_next_s[z] != state_r[z]) begin
            cnt_next_s[z] = '0;
         end else if (cnt_r[z] != DWELL_MAX) begin
            cnt_next_s[z] = cnt_r[z] + CNT_W'(1);
         end else begin
            cnt_next_s[z] = cnt_r[z];
         end
      end
   end

   // Zone state and dwell counter registers with asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int z = 0; z < N_ZONES; z++) begin
            state_r[z] <= ST_OFF;
            cnt_r[z]   <= '0;
         end
      end else begin
         for (int z = 0; z < N_ZONES; z++) begin
            state_r[z] <= state_next_s[z];
            cnt_r[z]   <= cnt_next_s[z];
         end
      end
   end

   // Output decode from the registered zone states
   always_comb begin
      action        = '1;
      state_display = '0;
      compressor_on = 1'b0;
      for (int z = 0; z < N_ZONES; z++) begin
         state_display[2*z +: 2] = state_r[z];
         case (state_r[z])
            ST_OFF:      action[2*z +: 2] = 2'b11;
            ST_DECREASE: action[2*z +: 2] = 2'b01;
            ST_INCREASE: action[2*z +: 2] = 2'b10;
            ST_IDLE:     action[2*z +: 2] = 2'b00;
            default:     action[2*z +: 2] = 2'b11;
         endcase
         if ((state_r[z] == ST_DECREASE) || (state_r[z] == ST_INCREASE)) begin
            compressor_on = 1'b1;
         end else begin
            compressor_on = compressor_on;
         end
      end
   end

endmodule

// File: doc/multi_zone_ac_controller.md
Name: multi_zone_ac_controller

Overview:
Parametrised successor of the single-zone AC controller. Runs N_ZONES independent 4-state climate FSMs from a shared power switch. Each zone compares its own temperature against its own setpoint with a hysteresis band, and enforces a minimum dwell time per state to protect the compressor. Sits between the sensor/setpoint registers and the per-zone actuator drivers and display.

Parameters:
N_ZONES, 2, number of independent zones (>=1)
TEMP_W, 8, width of each unsigned temperature/setpoint field
HYST, 2, hysteresis half-band in temperature LSBs (0 ≤ HYST < 2^TEMP_W)
MIN_DWELL, 16, minimum cycles a zone holds DECREASE/INCREASE/IDLE before a non-OFF exit (>=1; 1 = no restriction)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
power  input  1  global enable; 0 forces all zones to OFF
setpoint  input  N_ZONES*TEMP_W  zone z at bits [z*TEMP_W +: TEMP_W], unsigned
temp  input  N_ZONES*TEMP_W  measured temperature, same packing, unsigned
action  output  2*N_ZONES  zone z at [2z+:2]; OFF=11, DECREASE=01, INCREASE=10, IDLE=00
state_display  output  2*N_ZONES  zone z at [2z+:2]; OFF=0, DECREASE=1, INCREASE=2, IDLE=3
compressor_on  output  1  OR over zones of (state is DECREASE or INCREASE)

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on port reset.
- Reset: all zone states = OFF and dwell counters = 0 immediately, without waiting for a clock edge. Outputs then read action = all 1s, state_display = 0, compressor_on = 0.
- Outputs are decoded combinationally from registered state. An input change is therefore visible on the outputs after 1 rising edge.
- Per-zone comparisons use TEMP_W+1-bit arithmetic, so there is no wrap:
  - hot = temp > setpoint + HYST
  - cold = temp + HYST < setpoint
  - band = neither hot nor cold
- Dwell counter per zone:
  - Cleared on every state change.
  - Otherwise increments each cycle, saturating at MIN_DWELL-1.
  - dwell_ok = (cnt == MIN_DWELL-1). Earliest non-OFF exit is MIN_DWELL edges after entry.
  - Width is $clog2(MIN_DWELL+1).
- Transitions (evaluated each edge; the power=0 rule has absolute priority and ignores dwell):
  - any state, power=0 -> OFF
  - OFF, power=1: hot -> DECREASE; cold -> INCREASE; band -> IDLE (no dwell needed)
  - DECREASE: temp <= setpoint and dwell_ok -> IDLE; else hold
  - INCREASE: temp >= setpoint and dwell_ok -> IDLE; else hold
  - IDLE: dwell_ok and hot -> DECREASE; dwell_ok and cold -> INCREASE; else hold
  - DECREASE and INCREASE never swap directly; the zone always passes through IDLE.
- Zones are fully independent apart from power and the optional stagger rule.
- Setpoint or temp changing while a zone is active: the new values are used at the next edge, still subject to dwell.
- Reset asserted mid-operation aborts every zone to OFF asynchronously. The first edge after release is evaluated from OFF.
- Illegal or unreachable encodings cannot arise from 2-bit states. The default arm recovers to OFF.

Optional Feature:
STAGGER_START_EN
- Defined:
  - At most one zone per edge may enter DECREASE or INCREASE from OFF or IDLE, limiting inrush current.
  - The lowest-index requesting zone wins. Blocked zones hold their current state, and their dwell counters keep saturating.
  - A blocked zone retries on the next edge.
  - OFF->IDLE, exits to IDLE, and power-off transitions are never blocked.
- Undefined: all zones transition simultaneously as specified above.

Test Plan:
All scenarios use N_ZONES=2, TEMP_W=8, HYST=2, MIN_DWELL=4.
- Async reset: assert reset between edges with zones active -> same instant action=4'b1111, state_display=4'b0000, compressor_on=0.
- Power on: power=1; z0 sp=70, temp=75; z1 sp=70, temp=71 -> after 1 edge z0 DECREASE (action[1:0]=01), z1 IDLE (00), compressor_on=1.
- Dwell: z0 enters DECREASE at edge E and temp drops to 70 at E+1 -> z0 stays DECREASE through E+3 and becomes IDLE at edge E+4.
- Hysteresis and boundaries, z0 IDLE with dwell satisfied:
  - sp=70, temp=72 -> stays IDLE; temp=73 -> DECREASE next edge.
  - sp=254, temp=255 -> IDLE.
  - sp=255, temp=0 -> INCREASE.
  - sp=0, temp=255 -> DECREASE (no wrap errors).
- Power drop mid-dwell: z0 in INCREASE 1 cycle after entry, power->0 -> OFF on the next edge regardless of dwell. Power->1 with band temp -> IDLE next edge.
- Stagger (STAGGER_START_EN defined): both zones OFF, both cold (sp=80, temp=60), power=1 -> z0 INCREASE at edge 1, z1 INCREASE at edge 2. Without the macro, both enter INCREASE at edge 1.
